cond_unit: RTL and testbench
============================

# cond_unit

Parametrised execute-stage conditional-execution unit for the pipelined ARM core. It owns the NZCV flag register and evaluates the condition for the instruction in Execute. It gates that instruction's architectural side effects: register write, memory write, PC write, branch and flag update. It also adds a Thumb-style IT-block state machine, so up to IT_MAX_LEN following instructions execute under conditions taken from the IT instruction. The unit sits between the Decode→Execute pipeline register and the Execute→Memory pipeline register.

## Interface
Parameters:
- IT_MAX_LEN, 4: maximum IT block length accepted, legal range 1..4.
- RESET_FLAGS, 4'b0000: NZCV value loaded on reset.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- ValidE  in  1  Execute stage holds a real instruction.
- StallE  in  1  Execute stage holds its instruction this cycle.
- FlushE  in  1  instruction in Execute is squashed.
- CondE  in  4  condition field of the instruction.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagWriteE  in  2  [1] writes N,Z; [0] writes C,V.
- PCSrcE, RegWriteE, MemWriteE, NoWriteE, BranchE  in  1 each  raw decoded controls.
- ITStartE  in  1  instruction in Execute is an IT instruction.
- ITFirstCond  in  4  firstcond field of the IT instruction.
- ITMask  in  4  mask field of the IT instruction.
- PCSrcEout, RegWriteEout, MemWriteEout, BranchTakenE  out  1 each  gated controls.
- CondExE  out  1  effective condition passed.
- Flags  out  4  current NZCV register.
- ITActive  out  1  an IT block is in progress.
- ITRemaining  out  3  instructions left in the IT block, 0..4.
- ITErr  out  1  single-cycle pulse: an IT instruction was rejected.

## Operation
- Fire = ValidE & ~StallE & ~FlushE & ~reset. Nothing sequential changes unless Fire is high, except on reset.
- Effective condition (EffCond):
  - ITActive: EffCond = ITState[7:4], and CondE is ignored.
  - Otherwise: EffCond = CondE.
- Condition evaluation:
  - Codes 0000..1101 follow the standard ARM meanings (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE).
  - 1110 (AL) evaluates true.
  - 1111 evaluates false. It is never X.
- CondExE = eval(EffCond, Flags) & ValidE & ~FlushE.
- Gated controls:
  - RegWriteEout = RegWriteE & CondExE & ~NoWriteE.
  - MemWriteEout = MemWriteE & CondExE.
  - PCSrcEout = PCSrcE & CondExE.
  - BranchTakenE = BranchE & CondExE.
  - All four are forced 0 while reset is high or StallE is high.
- Flag update on Fire & CondExE:
  - FlagWriteE[1] loads N,Z from ALUFlags[3:2].
  - FlagWriteE[0] loads C,V from ALUFlags[1:0].
  - The two halves are independent.
- ITState is 8 bits: {cond[3:0], mask[3:0]}.
  - ITActive = (ITState[3:0] != 0).
  - ITRemaining = number of bits from the lowest set mask bit up to bit 3, inclusive. It is 0 when idle.
- IT entry (Fire & ITStartE):
  - Conditions to accept: not ITActive, ITMask != 0, block length ≤ IT_MAX_LEN, ITFirstCond != 1111.
  - When accepted: ITState <= {ITFirstCond, ITMask}.
  - Otherwise the IT is treated as a NOP: ITErr = 1 for that cycle and ITState is unchanged.
  - The IT instruction itself is always unconditional and writes nothing.
- IT advance (Fire & ITActive & ~ITStartE):
  - If ITState[2:0] == 0, ITState <= 0.
  - Otherwise ITState[4:0] <= ITState[4:0] << 1.
  - A failed condition still advances the block.
- IT abort: Fire with PCSrcEout or BranchTakenE high clears ITState to 0. Abort takes priority over advance.

## Timing
- Gated controls and CondExE are combinational in the same cycle. Flags and ITState update at the rising edge that ends a Fire cycle.
- The next instruction in Execute sees the updated flags and ITState with zero-cycle penalty. No bypass is required.
- StallE holds Flags and ITState; the stalled instruction re-evaluates on the following cycle.
- FlushE squashes the instruction: no flag write, no IT advance, no IT entry.
- Reset (asynchronous, mid-block or any time):
  - Flags = RESET_FLAGS, ITState = 0, ITActive = 0, ITRemaining = 0, ITErr = 0.
  - Gated controls = 0.

## Configuration
- COND_IT_EN defined: IT state machine is built as described above.
- COND_IT_EN undefined:
  - No ITState register; ITStartE, ITFirstCond and ITMask are ignored.
  - ITActive, ITRemaining and ITErr are tied to 0.
  - EffCond = CondE always.

## Structure
- Package cond_pkg holds:
  - cond_e enum (EQ..AL, NV).
  - NZCV bit index constants.
  - it_state_t packed struct {cond, mask}.
  - it_len() function returning block length from a mask.
- Sub-module cond_eval: purely combinational (EffCond, Flags) → pass. It is shared with the branch predictor checker.

## Test plan
- Reset mid-IT block: reset pulses while ITRemaining=2 → Flags=RESET_FLAGS, ITActive=0 and all outputs 0 immediately, without waiting for a clock edge.
- Split flag writes: Flags=0000, ALUFlags=1111, FlagWriteE=10, CondE=1110 → Flags=1100. Then FlagWriteE=01 with ALUFlags=0011 → Flags=1111.
- Condition gating: Flags Z=1, CondE=0001 (NE), RegWriteE=1, MemWriteE=1 → RegWriteEout=0, MemWriteEout=0, no flag change. CondE=0000 → both 1.
- IT block "ITTE EQ": ITFirstCond=0000, ITMask=0110, Z=1. Next three instructions get EffCond EQ, EQ, NE: CondExE = 1, 1, 0, and ITRemaining goes 3→2→1→0.
- IT with stall/flush/abort: StallE for 2 cycles mid-block → ITRemaining unchanged. FlushE → no advance. Taken branch on 2nd of 4 → ITState=0 next cycle.
- IT rejection: IT_MAX_LEN=2, ITMask=0001 → ITErr=1 for one cycle, ITActive stays 0. Repeat with COND_IT_EN undefined → ITErr=0 and CondE is honoured.

Source files
------------

// File: rtl/cond_pkg.sv
// cond_pkg: shared types and helpers for the conditional-execution unit.
//   cond_e      - ARM condition codes (EQ..AL, NV)
//   N/Z/C/V_BIT - bit positions inside the NZCV vector
//   it_state_t  - IT block state {cond, mask}
//   it_len()    - IT block length encoded by a mask (0 when mask is 0)
package cond_pkg;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    typedef struct packed {
        logic [3:0] cond;
        logic [3:0] mask;
    } it_state_t;

    // Length runs from the lowest set mask bit up to bit 3 inclusive.
    function automatic logic [2:0] it_len(input logic [3:0] mask);
        if (mask[0])      return 3'd4;
        else if (mask[1]) return 3'd3;
        else if (mask[2]) return 3'd2;
        else if (mask[3]) return 3'd1;
        else              return 3'd0;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational ARM condition check, shared with the
// branch predictor checker.
//   cond  in  4  condition code
//   flags in  4  {N,Z,C,V}
//   pass  out 1  condition holds (NV always fails, never X)
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[N_BIT];
        z    = flags[Z_BIT];
        c    = flags[C_BIT];
        v    = flags[V_BIT];
        pass = 1'b0;
        case (cond)
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: execute-stage conditional execution. Owns NZCV, evaluates the
// effective condition, gates reg/mem/PC/branch side effects, and (when the
// COND_IT_EN macro is defined) runs a Thumb-style IT block state machine.
// Without COND_IT_EN the IT inputs are ignored and IT outputs read 0.
//   clk, reset            clock, async active-high reset
//   ValidE/StallE/FlushE  execute stage qualifiers
//   CondE, ALUFlags, FlagWriteE, PCSrcE, RegWriteE, MemWriteE, NoWriteE,
//   BranchE               raw decoded controls
//   ITStartE/ITFirstCond/ITMask  IT instruction fields
//   PCSrcEout, RegWriteEout, MemWriteEout, BranchTakenE  gated controls
//   CondExE, Flags, ITActive, ITRemaining, ITErr          status
module cond_unit
    import cond_pkg::*;
#(
    parameter int         IT_MAX_LEN  = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ValidE,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic [3:0] CondE,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWriteE,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    input  logic       NoWriteE,
    input  logic       BranchE,
    input  logic       ITStartE,
    input  logic [3:0] ITFirstCond,
    input  logic [3:0] ITMask,
    output logic       PCSrcEout,
    output logic       RegWriteEout,
    output logic       MemWriteEout,
    output logic       BranchTakenE,
    output logic       CondExE,
    output logic [3:0] Flags,
    output logic       ITActive,
    output logic [2:0] ITRemaining,
    output logic       ITErr
);

    logic       fire;
    logic [3:0] eff_cond;
    logic       pass;
    logic       is_it;
    logic       gate;

    assign fire = ValidE & ~StallE & ~FlushE & ~reset;

`ifdef COND_IT_EN
    it_state_t it_q;
    logic      it_accept;

    assign ITActive    = (it_q.mask != 4'd0);
    assign ITRemaining = it_len(it_q.mask);
    assign eff_cond    = ITActive ? it_q.cond : CondE;
    assign is_it       = ITStartE;

    // Nested IT, empty mask, over-long block or NV firstcond are rejected.
    assign it_accept = ~ITActive && (ITMask != 4'd0)
                    && (int'(it_len(ITMask)) <= IT_MAX_LEN)
                    && (ITFirstCond != NV);
    assign ITErr     = fire & ITStartE & ~it_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            it_q <= '0;
        end else if (fire) begin
            if (PCSrcEout | BranchTakenE) begin
                it_q <= '0;
            end else if (ITStartE) begin
                if (it_accept) it_q <= {ITFirstCond, ITMask};
            end else if (ITActive) begin
                // Mask MSB becomes the next condition LSB; mask[3] alone is the last slot.
                if (it_q.mask[2:0] == 3'd0) it_q <= '0;
                else it_q <= {it_q.cond[3:1], it_q.mask[3], it_q.mask[2:0], 1'b0};
            end
        end
    end
`else
    logic unused_it;

    assign unused_it   = ^{ITStartE, ITFirstCond, ITMask, IT_MAX_LEN[2:0]};
    assign ITActive    = 1'b0;
    assign ITRemaining = 3'd0;
    assign ITErr       = 1'b0;
    assign eff_cond    = CondE;
    assign is_it       = 1'b0;
`endif

    cond_eval u_eval (
        .cond  (eff_cond),
        .flags (Flags),
        .pass  (pass)
    );

    assign CondExE = pass & ValidE & ~FlushE & ~reset;

    // The IT instruction itself never has side effects.
    assign gate         = ~reset & ~StallE & ~is_it;
    assign RegWriteEout = RegWriteE & CondExE & ~NoWriteE & gate;
    assign MemWriteEout = MemWriteE & CondExE & gate;
    assign PCSrcEout    = PCSrcE & CondExE & gate;
    assign BranchTakenE = BranchE & CondExE & gate;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= RESET_FLAGS;
        end else if (fire & CondExE & ~is_it) begin
            if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    localparam logic [3:0] RF = 4'b0100;
`ifdef COND_IT_EN
    localparam bit IT_EN = 1'b1;
`else
    localparam bit IT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ValidE = 0, StallE = 0, FlushE = 0;
    logic [3:0] CondE = 4'he, ALUFlags = 0;
    logic [1:0] FlagWriteE = 0;
    logic       PCSrcE = 0, RegWriteE = 0, MemWriteE = 0, NoWriteE = 0, BranchE = 0;
    logic       ITStartE = 0;
    logic [3:0] ITFirstCond = 0, ITMask = 0;

    logic       pcs_o [2];
    logic       rw_o  [2];
    logic       mw_o  [2];
    logic       br_o  [2];
    logic       cx_o  [2];
    logic [3:0] fl_o  [2];
    logic       act_o [2];
    logic [2:0] rem_o [2];
    logic       err_o [2];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cond_unit #(.IT_MAX_LEN(4), .RESET_FLAGS(RF)) dut (
        .clk(clk), .reset(rst), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .ALUFlags(ALUFlags), .FlagWriteE(FlagWriteE), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .NoWriteE(NoWriteE), .BranchE(BranchE),
        .ITStartE(ITStartE), .ITFirstCond(ITFirstCond), .ITMask(ITMask),
        .PCSrcEout(pcs_o[0]), .RegWriteEout(rw_o[0]), .MemWriteEout(mw_o[0]),
        .BranchTakenE(br_o[0]), .CondExE(cx_o[0]), .Flags(fl_o[0]), .ITActive(act_o[0]),
        .ITRemaining(rem_o[0]), .ITErr(err_o[0]));

    cond_unit #(.IT_MAX_LEN(2), .RESET_FLAGS(RF)) dut2 (
        .clk(clk), .reset(rst), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .ALUFlags(ALUFlags), .FlagWriteE(FlagWriteE), .PCSrcE(PCSrcE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .NoWriteE(NoWriteE), .BranchE(BranchE),
        .ITStartE(ITStartE), .ITFirstCond(ITFirstCond), .ITMask(ITMask),
        .PCSrcEout(pcs_o[1]), .RegWriteEout(rw_o[1]), .MemWriteEout(mw_o[1]),
        .BranchTakenE(br_o[1]), .CondExE(cx_o[1]), .Flags(fl_o[1]), .ITActive(act_o[1]),
        .ITRemaining(rem_o[1]), .ITErr(err_o[1]));

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: NZCV value and the list of conditions still owed to the
    // IT block (head = condition of the next instruction).
    logic [3:0] mf   [2] = '{RF, RF};
    logic [3:0] pend [2][4];
    int         cnt  [2] = '{0, 0};

    function automatic logic meval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'd15) return 1'b0;
        return (c[0] && c != 4'd14) ? !base : base;
    endfunction

    function automatic int mlen(input logic [3:0] m);
        int l = 0;
        for (int b = 3; b >= 0; b--) if (m[b]) l = 4 - b;
        return l;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mf[0] = RF; mf[1] = RF; cnt[0] = 0; cnt[1] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eff;
            logic fire, cx, isit, g, acc, e_rw, e_mw, e_pc, e_br, e_err;
            int   maxl, l;
            maxl = (k == 0) ? 4 : 2;
            eff  = (cnt[k] > 0) ? pend[k][0] : CondE;
            fire = ValidE && !StallE && !FlushE && !rst;
            cx   = meval(eff, mf[k]) && ValidE && !FlushE && !rst;
            isit = IT_EN && ITStartE;
            g    = !rst && !StallE && !isit;
            l    = mlen(ITMask);
            acc  = (cnt[k] == 0) && (l > 0) && (l <= maxl) && (ITFirstCond != 4'd15);
            e_rw = RegWriteE && cx && !NoWriteE && g;
            e_mw = MemWriteE && cx && g;
            e_pc = PCSrcE && cx && g;
            e_br = BranchE && cx && g;
            e_err = IT_EN && fire && ITStartE && !acc;
            chk($sformatf("u%0d.RegWriteEout", k), {7'd0, rw_o[k]}, {7'd0, e_rw});
            chk($sformatf("u%0d.MemWriteEout", k), {7'd0, mw_o[k]}, {7'd0, e_mw});
            chk($sformatf("u%0d.PCSrcEout", k), {7'd0, pcs_o[k]}, {7'd0, e_pc});
            chk($sformatf("u%0d.BranchTakenE", k), {7'd0, br_o[k]}, {7'd0, e_br});
            chk($sformatf("u%0d.CondExE", k), {7'd0, cx_o[k]}, {7'd0, cx});
            chk($sformatf("u%0d.Flags", k), {4'd0, fl_o[k]}, {4'd0, mf[k]});
            chk($sformatf("u%0d.ITActive", k), {7'd0, act_o[k]}, {7'd0, cnt[k] > 0});
            chk($sformatf("u%0d.ITRemaining", k), {5'd0, rem_o[k]}, 8'(cnt[k]));
            chk($sformatf("u%0d.ITErr", k), {7'd0, err_o[k]}, {7'd0, e_err});
            // next state, using the inputs that will be present at the next rising edge
            if (fire && cx && !isit) begin
                if (FlagWriteE[1]) mf[k][3:2] = ALUFlags[3:2];
                if (FlagWriteE[0]) mf[k][1:0] = ALUFlags[1:0];
            end
            if (IT_EN && fire) begin
                if (e_pc || e_br) cnt[k] = 0;
                else if (ITStartE) begin
                    if (acc) begin
                        pend[k][0] = ITFirstCond;
                        for (int i = 1; i < l; i++) pend[k][i] = {ITFirstCond[3:1], ITMask[4-i]};
                        cnt[k] = l;
                    end
                end else if (cnt[k] > 0) begin
                    for (int i = 0; i < 3; i++) pend[k][i] = pend[k][i+1];
                    cnt[k] = cnt[k] - 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ValidE = 0; StallE = 0; FlushE = 0; CondE = 4'he; ALUFlags = 0; FlagWriteE = 0;
        PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; NoWriteE = 0; BranchE = 0;
        ITStartE = 0; ITFirstCond = 0; ITMask = 0;
    endtask

    task automatic op(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                      input logic rw, input logic mw, input logic br);
        idle();
        ValidE = 1; CondE = c; ALUFlags = alu; FlagWriteE = fw;
        RegWriteE = rw; MemWriteE = mw; BranchE = br; PCSrcE = br;
    endtask

    task automatic it(input logic [3:0] fc, input logic [3:0] m);
        idle();
        ValidE = 1; ITStartE = 1; ITFirstCond = fc; ITMask = m;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        chk("reset Flags", {4'd0, fl_o[0]}, {4'd0, RF});
        chk("reset ITActive", {7'd0, act_o[0]}, 8'd0);
        rst = 0;
        tick();

        // split flag writes
        op(4'he, 4'b1111, 2'b10, 0, 0, 0); tick();
        chk("split NZ", {4'd0, fl_o[0]}, 8'h0c);
        op(4'he, 4'b0011, 2'b01, 0, 0, 0); tick();
        chk("split CV", {4'd0, fl_o[0]}, 8'h0f);

        // condition gating, Z=1
        op(4'h1, 4'b0000, 2'b11, 1, 1, 0); #1;
        chk("NE RegWrite", {7'd0, rw_o[0]}, 8'd0);
        chk("NE MemWrite", {7'd0, mw_o[0]}, 8'd0);
        tick();
        chk("NE no flag change", {4'd0, fl_o[0]}, 8'h0f);
        op(4'h0, 4'b0000, 2'b00, 1, 1, 0); #1;
        chk("EQ RegWrite", {7'd0, rw_o[0]}, 8'd1);
        chk("EQ MemWrite", {7'd0, mw_o[0]}, 8'd1);
        tick();

        // ITTE EQ with Z=1: CondExE 1,1,0
        it(4'h0, 4'b0110); #1;
`ifdef COND_IT_EN
        chk("ITTE len3 on max2 ITErr", {7'd0, err_o[1]}, 8'd1);
`endif
        chk("IT instr no RegWrite", {7'd0, rw_o[0]}, 8'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            op(4'he, 4'b0000, 2'b00, 1, 0, 0); #1;
`ifdef COND_IT_EN
            chk("ITTE remaining", {5'd0, rem_o[0]}, 8'(3 - i));
            chk("ITTE CondExE", {7'd0, cx_o[0]}, (i == 2) ? 8'd0 : 8'd1);
`else
            chk("no-IT CondE honoured", {7'd0, cx_o[0]}, 8'd1);
            chk("no-IT ITErr", {7'd0, err_o[0]}, 8'd0);
`endif
            tick();
        end
        idle(); #1;
        chk("ITTE done", {5'd0, rem_o[0]}, 8'd0);
        tick();

        // 4-long block: stall, flush, then taken branch on the 2nd instruction
        it(4'h0, 4'b0001); #1;
`ifdef COND_IT_EN
        chk("len4 on max2 ITErr", {7'd0, err_o[1]}, 8'd1);
`endif
        tick();
        op(4'he, 4'b0000, 2'b00, 1, 0, 0); tick();
        op(4'he, 4'b0000, 2'b00, 1, 0, 0); StallE = 1; #1;
        chk("stall gates RegWrite", {7'd0, rw_o[0]}, 8'd0);
        tick(); tick();
`ifdef COND_IT_EN
        chk("stall keeps remaining", {5'd0, rem_o[0]}, 8'd3);
        chk("max2 stays idle", {7'd0, act_o[1]}, 8'd0);
`endif
        StallE = 0; FlushE = 1; tick();
`ifdef COND_IT_EN
        chk("flush keeps remaining", {5'd0, rem_o[0]}, 8'd3);
`endif
        op(4'he, 4'b0000, 2'b00, 0, 0, 1); #1;
        chk("branch taken", {7'd0, br_o[0]}, 8'd1);
        tick();
        idle(); #1;
        chk("abort clears IT", {7'd0, act_o[0]}, 8'd0);
        tick();

        // other rejections: NV firstcond, empty mask, nested IT
        it(4'hf, 4'b1000); tick();
        it(4'h0, 4'b0000); tick();
        it(4'h1, 4'b1000); tick();
        it(4'h0, 4'b1000); tick();
        op(4'he, 4'b0000, 2'b00, 1, 0, 0); tick();

        // reset mid-IT block with two instructions left
        it(4'h0, 4'b0110); tick();
        op(4'he, 4'b0000, 2'b00, 1, 1, 0); tick();
        op(4'he, 4'b1011, 2'b11, 1, 1, 0); #1;
`ifdef COND_IT_EN
        chk("pre-reset remaining", {5'd0, rem_o[0]}, 8'd2);
`endif
        #1 rst = 1; #1;
        chk("async reset Flags", {4'd0, fl_o[0]}, {4'd0, RF});
        chk("async reset ITActive", {7'd0, act_o[0]}, 8'd0);
        chk("async reset ITRemaining", {5'd0, rem_o[0]}, 8'd0);
        chk("async reset RegWrite", {7'd0, rw_o[0]}, 8'd0);
        chk("async reset MemWrite", {7'd0, mw_o[0]}, 8'd0);
        chk("async reset CondExE", {7'd0, cx_o[0]}, 8'd0);
        tick();
        rst = 0;
        tick();

        // sweep every condition code against every flag pattern
        for (int f = 0; f < 16; f++) begin
            op(4'he, 4'(f), 2'b11, 0, 0, 0); tick();
            for (int c = 0; c < 16; c++) begin
                op(4'(c), 4'(15 - f), 2'(c), 1, 1, 0); NoWriteE = c[3]; tick();
                op(4'he, 4'(f), 2'b11, 0, 0, 0); tick();
            end
        end
        idle(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
